// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the register file write port: buffers requests,
// issues one registered write per cycle and exposes pending values for forwarding.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          pend1,
  output logic          pend2,
  output logic [DW-1:0] fwd1,
  output logic [DW-1:0] fwd2,
  output logic          empty,
  output logic [7:0]    drop_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PC_ADDR = AW'(15);
  localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          we3_q, we3_d;
  logic [AW-1:0] wa3_q, wa3_d;
  logic [DW-1:0] wd3_q, wd3_d;
  logic [7:0]    drop_q, drop_d;

  logic [AW-1:0] mem_addr_q [DEPTH];
  logic [DW-1:0] mem_data_q [DEPTH];

  logic accept, push, drop, pop;

  // Readiness depends only on registered occupancy, never on this cycle's pop.
  assign in_ready = reset & (count_q != FULL);
  assign empty    = (count_q == '0) & ~we3_q;
  assign we3      = we3_q;
  assign wa3      = wa3_q;
  assign wd3      = wd3_q;
  assign drop_cnt = drop_q;

  always_comb begin
    accept   = in_valid & in_ready;
    push     = accept & (in_addr != PC_ADDR);
    drop     = accept & (in_addr == PC_ADDR);
    pop      = (count_q != '0);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    we3_d  = pop;
    wa3_d  = pop ? mem_addr_q[rd_ptr_q] : wa3_q;
    wd3_d  = pop ? mem_data_q[rd_ptr_q] : wd3_q;
    drop_d = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
      drop_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage needs no reset: occupancy decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= in_addr;
      mem_data_q[wr_ptr_q] <= in_data;
    end
  end

  logic [DEPTH-1:0]         ent_valid;
  logic [DEPTH-1:0][PW-1:0] ent_age;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign ent_age[gi]   = PW'(gi) - rd_ptr_q;
    assign ent_valid[gi] = ({1'b0, ent_age[gi]} < count_q);
  end

  logic [1:0][AW-1:0] ra_v;
  logic [1:0]         pend_v;
  logic [1:0][DW-1:0] fwd_v;

  assign ra_v = {ra2, ra1};

  // Youngest match wins: the largest age in the FIFO, else the output register.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
    logic          port_hit;
    logic          fifo_hit;
    logic [PW-1:0] best_age;
    logic [DW-1:0] best_data;
    logic          hit;

    always_comb begin
      port_hit  = we3_q && (wa3_q == ra_v[gi]);
      fifo_hit  = 1'b0;
      best_age  = '0;
      best_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && (mem_addr_q[i] == ra_v[gi]) &&
            (!fifo_hit || (ent_age[i] > best_age))) begin
          fifo_hit  = 1'b1;
          best_age  = ent_age[i];
          best_data = mem_data_q[i];
        end
      end
      hit = (fifo_hit || port_hit) && (ra_v[gi] != PC_ADDR);
    end

    assign pend_v[gi] = hit;
    assign fwd_v[gi]  = !hit ? '0 : (fifo_hit ? best_data : wd3_q);
  end

  assign pend1 = pend_v[0];
  assign pend2 = pend_v[1];
  assign fwd1  = fwd_v[0];
  assign fwd2  = fwd_v[1];

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scenario bench for regfile_wb_queue: directed tasks plus a negedge scoreboard
// that predicts every write-port, readiness and lookup value.
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_addr = '0;
  logic [31:0] in_data = '0;
  logic        we3;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic [3:0]  ra1 = '0;
  logic [3:0]  ra2 = '0;
  logic        pend1, pend2;
  logic [31:0] fwd1, fwd2;
  logic        empty;
  logic [7:0]  drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  regfile_wb_queue #(.DEPTH(DEPTH), .AW(4), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .pend1(pend1), .pend2(pend2), .fwd1(fwd1), .fwd2(fwd2),
    .empty(empty), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
  } ent_t;

  // Scoreboard: every accepted write not yet retired from the port, oldest first.
  ent_t        sb[$];
  logic        m_we = 1'b0;
  logic [3:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  int          m_drop = 0;
  int          n_issued = 0;

  always @(negedge clk) begin : mon
    int          mcount;
    logic [3:0]  ra;
    logic        ep;
    logic [31:0] ef;
    logic        acc;
    logic        iss;
    if (!reset) begin
      sb.delete();
      m_we = 1'b0; m_wa = '0; m_wd = '0; m_drop = 0;
    end else begin
      mcount = sb.size() - (m_we ? 1 : 0);
      n_assert++;
      if (we3 !== m_we || wa3 !== m_wa || wd3 !== m_wd) begin
        n_fail++;
        $display("FAIL mon_port t=%0t: got we3=%b wa3=%h wd3=%h expected we3=%b wa3=%h wd3=%h",
                 $time, we3, wa3, wd3, m_we, m_wa, m_wd);
      end
      n_assert++;
      if (in_ready !== (mcount != DEPTH) || empty !== (mcount == 0 && !m_we)) begin
        n_fail++;
        $display("FAIL mon_status t=%0t: got in_ready=%b empty=%b expected in_ready=%b empty=%b",
                 $time, in_ready, empty, mcount != DEPTH, mcount == 0 && !m_we);
      end
      n_assert++;
      if (drop_cnt !== 8'(m_drop)) begin
        n_fail++;
        $display("FAIL mon_drop t=%0t: got %0d expected %0d", $time, drop_cnt, m_drop);
      end
      for (int p = 0; p < 2; p++) begin
        ra = (p == 0) ? ra1 : ra2;
        ep = 1'b0;
        ef = '0;
        if (ra != 4'd15) begin
          for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].a == ra) begin
              ep = 1'b1;
              ef = sb[i].d;
              break;
            end
          end
        end
        n_assert++;
        if ((p == 0 && (pend1 !== ep || fwd1 !== ef)) ||
            (p == 1 && (pend2 !== ep || fwd2 !== ef))) begin
          n_fail++;
          $display("FAIL mon_lookup%0d t=%0t ra=%h: got pend=%b fwd=%h expected pend=%b fwd=%h",
                   p + 1, $time, ra, (p == 0) ? pend1 : pend2, (p == 0) ? fwd1 : fwd2, ep, ef);
        end
      end
      // Predict the coming posedge.
      acc = in_valid && (mcount != DEPTH);
      iss = (mcount != 0);
      if (m_we) void'(sb.pop_front());
      if (iss) begin
        m_wa = sb[0].a;
        m_wd = sb[0].d;
        n_issued++;
      end
      m_we = iss;
      if (acc && in_addr != 4'd15) sb.push_back({in_addr, in_data});
      if (acc && in_addr == 4'd15 && m_drop < 255) m_drop++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    n_assert++;
    if (in_ready !== 1'b0 || we3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_low: got in_ready=%b we3=%b expected 0 0", in_ready, we3);
    end
    reset = 1'b1;
    #1;
    n_assert++;
    if (in_ready !== 1'b1 || empty !== 1'b1 || we3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b empty=%b we3=%b expected 1 1 0", in_ready, empty, we3);
    end
    n_assert++;
    if (drop_cnt !== 8'd0 || wa3 !== 4'd0 || wd3 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got drop=%0d wa3=%h wd3=%h expected 0 0 0", drop_cnt, wa3, wd3);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    cyc();
    ra1 = 4'd3;
    in_valid = 1'b1; in_addr = 4'd3; in_data = 32'hDEADBEEF;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    n_assert++;
    if (we3 !== 1'b0 || pend1 !== 1'b1 || fwd1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_queued: got we3=%b pend1=%b fwd1=%h expected 0 1 deadbeef", we3, pend1, fwd1);
    end
    cyc();
    @(negedge clk);
    n_assert++;
    if (we3 !== 1'b1 || wa3 !== 4'd3 || wd3 !== 32'hDEADBEEF || pend1 !== 1'b1 || fwd1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_port: got we3=%b wa3=%h wd3=%h pend1=%b fwd1=%h expected 1 3 deadbeef 1 deadbeef",
               we3, wa3, wd3, pend1, fwd1);
    end
    cyc();
    @(negedge clk);
    n_assert++;
    if (we3 !== 1'b0 || pend1 !== 1'b0 || fwd1 !== 32'd0) begin
      n_fail++;
      $display("FAIL single_done: got we3=%b pend1=%b fwd1=%h expected 0 0 0", we3, pend1, fwd1);
    end
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; in_addr = 4'(i + 1); in_data = 32'h100 + 32'(i + 1);
      end else begin
        in_valid = 1'b0;
      end
      cyc();
      @(negedge clk);
      if (i >= 1 && i <= 4) begin
        n_assert++;
        if (we3 !== 1'b1 || wa3 !== 4'(i) || wd3 !== 32'h100 + 32'(i)) begin
          n_fail++;
          $display("FAIL b2b_order%0d: got we3=%b wa3=%h wd3=%h expected 1 %h %h",
                   i, we3, wa3, wd3, 4'(i), 32'h100 + 32'(i));
        end
      end
    end
    n_assert++;
    if (we3 !== 1'b0 || empty !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_drain: got we3=%b empty=%b in_ready=%b expected 0 1 1", we3, empty, in_ready);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_same_addr();
    logic [31:0] exp_fwd [4];
    logic        exp_we  [4];
    logic [31:0] exp_wd  [4];
    exp_fwd = '{32'h11, 32'h22, 32'h22, 32'h0};
    exp_we  = '{1'b0, 1'b1, 1'b1, 1'b0};
    exp_wd  = '{32'h0, 32'h11, 32'h22, 32'h0};
    ra1 = 4'd5;
    ra2 = 4'd3;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i < 2);
      in_addr  = 4'd5;
      in_data  = (i == 0) ? 32'h11 : 32'h22;
      cyc();
      @(negedge clk);
      n_assert++;
      if (fwd1 !== exp_fwd[i] || pend1 !== (i < 3) || pend2 !== 1'b0) begin
        n_fail++;
        $display("FAIL same_fwd%0d: got pend1=%b fwd1=%h pend2=%b expected %b %h 0",
                 i, pend1, fwd1, pend2, i < 3, exp_fwd[i]);
      end
      n_assert++;
      if (we3 !== exp_we[i] || (exp_we[i] && (wd3 !== exp_wd[i] || wa3 !== 4'd5))) begin
        n_fail++;
        $display("FAIL same_issue%0d: got we3=%b wa3=%h wd3=%h expected %b 5 %h",
                 i, we3, wa3, wd3, exp_we[i], exp_wd[i]);
      end
    end
    $display("test_same_addr done");
  endtask

  task automatic test_pc_drop();
    int pulses = 0;
    int pend_seen = 0;
    in_valid = 1'b1; in_addr = 4'd15; ra1 = 4'd15; ra2 = 4'd15;
    for (int i = 0; i < 300; i++) begin
      in_data = $urandom;
      cyc();
      @(negedge clk);
      if (we3) pulses++;
      if (pend1 || pend2) pend_seen++;
    end
    in_valid = 1'b0;
    n_assert++;
    if (pulses != 0 || pend_seen != 0) begin
      n_fail++;
      $display("FAIL pc_nowrite: got we3 pulses=%0d pend hits=%0d expected 0 0", pulses, pend_seen);
    end
    n_assert++;
    if (drop_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL pc_drop_cnt: got %0d expected 255", drop_cnt);
    end
    $display("test_pc_drop done");
  endtask

  task automatic test_random();
    int start_issued = n_issued;
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      in_addr = 4'($urandom_range(0, 15));
      in_data = $urandom;
      ra1     = 4'($urandom_range(0, 15));
      ra2     = 4'($urandom_range(0, 15));
      cyc();
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    n_assert++;
    if ((n_issued - start_issued) / DEPTH < 100) begin
      n_fail++;
      $display("FAIL random_wraps: got %0d pointer wraps expected at least 100",
               (n_issued - start_issued) / DEPTH);
    end
    $display("test_random done issued=%0d", n_issued - start_issued);
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_addr = 4'(i + 6); in_data = 32'hA000 + 32'(i);
      cyc();
    end
    n_assert++;
    if (we3 !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_busy: got we3=%b expected 1", we3);
    end
    #1;
    reset = 1'b0;
    #1;
    n_assert++;
    if (we3 !== 1'b0 || empty !== 1'b1 || in_ready !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL areset_now: got we3=%b empty=%b in_ready=%b drop=%0d expected 0 1 0 0",
               we3, empty, in_ready, drop_cnt);
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_assert++;
    if (we3 !== 1'b0 || empty !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_release: got we3=%b empty=%b in_ready=%b expected 0 1 1", we3, empty, in_ready);
    end
    in_valid = 1'b1; in_addr = 4'd9; in_data = 32'h1234;
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_same_addr();
    test_pc_drop();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
